// File: rtl/rose_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rose_window_ctrl
// Brief    : Attempt sequencer for start |-> ##[MIN_DLY:MAX_DLY] $rose(signal_in).
//            Accepts one attempt at a time, opens the rose window between
//            offsets MIN_DLY and MAX_DLY and issues one-cycle pass/fail pulses.
// Options  : ROSE_WIN_DROP_CNT_EN - when defined, drop_cnt counts starts that
//            arrive while an attempt is running (saturating at 255).
// Revision : 1.0 - initial release
// ============================================================================
module rose_window_ctrl #(
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 4,
  parameter int CNT_W   = $clog2(MAX_DLY + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       start,
  input  logic       abort,
  input  logic       signal_in,
  output logic       busy,
  output logic       arm,
  output logic       pass,
  output logic       fail,
  output logic [7:0] drop_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_WINDOW = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_MIN_M1 = CNT_W'(MIN_DLY - 1);
  localparam logic [CNT_W-1:0] C_MAX    = CNT_W'(MAX_DLY);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_prev_q;
  logic             w_rose;
  logic             w_accept;
  logic             w_pass_nxt;
  logic             w_fail_nxt;

  // A rose is a 0 at the previous edge followed by a 1 at this edge.
  assign w_rose   = signal_in & ~r_prev_q;
  // busy is high exactly when the FSM is out of IDLE, so a start on the
  // verdict edge is still rejected.
  assign w_accept = start & en & ~busy;

  // Edge-history register, sampled every edge regardless of state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev_q <= 1'b0;
    else        r_prev_q <= signal_in;
  end

  // State, offset counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      busy    <= 1'b0;
      arm     <= 1'b0;
      pass    <= 1'b0;
      fail    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      busy    <= (w_state_nxt != ST_IDLE);
      arm     <= (w_state_nxt == ST_WINDOW);
      pass    <= w_pass_nxt;
      fail    <= w_fail_nxt;
    end
  end

  // Next-state, counter and verdict decode; abort outranks rose and timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pass_nxt  = 1'b0;
    w_fail_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_cnt_nxt   = C_ONE;
          w_state_nxt = (MIN_DLY > 1) ? ST_WAIT : ST_WINDOW;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
          if (r_cnt == C_MIN_M1) w_state_nxt = ST_WINDOW;
        end
      end
      ST_WINDOW: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_rose) begin
          w_pass_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == C_MAX) begin
          w_fail_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef ROSE_WIN_DROP_CNT_EN
  // Count starts rejected because an attempt is running; sticks at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= 8'd0;
    end else if (start && en && busy && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`else
  assign drop_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: doc/rose_window_ctrl.md
# rose_window_ctrl

Attempt sequencer for the sampled-value checker library: evaluates the property `start |-> ##[MIN_DLY:MAX_DLY] $rose(signal_in)`. It accepts one attempt at a time, tracks the elapsed cycle count and windows the rose detection. It issues one-cycle `pass`/`fail` verdicts. It sits between the trigger logic of an assertion and the `$rose` edge datapath, and owns when that datapath is armed.

## Interface
- `MIN_DLY`, default 1: first cycle offset (≥1) at which a rose is accepted.
- `MAX_DLY`, default 4: last accepted offset; must satisfy MIN_DLY ≤ MAX_DLY ≤ 255.
- `CNT_W`, default `$clog2(MAX_DLY+1)`: width of the offset counter.
- `clk` in 1: clock. Single clock domain.
- `rst_n` in 1: reset. Asynchronous, active-low.
- `en` in 1: global enable. Gates acceptance of new attempts only.
- `start` in 1: attempt trigger, sampled at posedge.
- `abort` in 1: cancels the running attempt with no verdict.
- `signal_in` in 1: monitored signal.
- `busy` out 1: attempt in progress.
- `arm` out 1: high while the rose window is open (state WINDOW).
- `pass` out 1: one-cycle verdict pulse, rose found in window.
- `fail` out 1: one-cycle verdict pulse, no rose by MAX_DLY.
- `drop_cnt` out 8: starts ignored while busy (see Configuration).

## Operation
- `prev_q` samples `signal_in` every edge, independent of state. It resets to 0.
- A rose at edge t means: `signal_in`=1 at edge t and `prev_q`=0, i.e. the value sampled at edge t-1 was 0.
- States are IDLE, WAIT and WINDOW. The offset counter `cnt` is CNT_W bits and resets to 0.
- IDLE → (start & en & ~busy at edge k): `cnt`←1. The next state is WAIT if MIN_DLY>1, else WINDOW.
- WAIT: `cnt` increments each edge. When `cnt`==MIN_DLY-1 the next state is WINDOW. A rose in WAIT is ignored.
- WINDOW, at the edge where `cnt`=d:
  - If a rose occurs: `pass`←1 and the next state is IDLE.
  - Else if d==MAX_DLY: `fail`←1 and the next state is IDLE.
  - Else `cnt` increments.
- `abort` at any edge in WAIT or WINDOW: the next state is IDLE, with no pass or fail. Abort beats a rose or timeout at the same edge. Abort in IDLE has no effect.
- `start` while busy is ignored and does not restart the attempt. `start` while `en`=0 is ignored and not counted as a drop.
- `en` falling during an attempt does not stop that attempt.
- `pass` and `fail` are mutually exclusive and never high for two consecutive cycles from the same attempt.

## Timing
- All outputs are registered.
- Reset values: `busy`=0, `arm`=0, `pass`=0, `fail`=0, `drop_cnt`=0. State resets to IDLE.
- Offset d is counted from the accepting edge k. The verdict for a rose at edge k+d is visible in the cycle after edge k+d.
- `busy` rises after edge k and falls at the same edge that asserts `pass` or `fail`, or at the abort edge.
- A `start` at the verdict edge is ignored, because `busy` is still high. The earliest re-accept is the following edge.
- Worst-case latency from start to verdict is MAX_DLY cycles.
- Asserting `rst_n` mid-attempt clears state immediately. No verdict is issued.

## Configuration
- `ROSE_WIN_DROP_CNT_EN` defined: `drop_cnt` increments on each edge with start & en & busy. It saturates at 255 and clears only on reset.
- Macro undefined: `drop_cnt` is tied to 0 and no counter logic is generated.

## Test plan
All scenarios use MIN_DLY=2, MAX_DLY=4.
- Rose inside the window: start at edge 0 and `signal_in` 0→1 at edge 3 → `pass`=1 in cycle 3–4, `busy` low from edge 3, `fail` never asserted.
- Early rose only: `signal_in` rises at edge 1 and stays high → no rose in window, `fail` pulses after edge 4, `pass`=0.
- Window edges: a rose at exactly d=2 gives `pass`, and a rose at exactly d=4 gives `pass`. A rose at d=5 gives `fail` at edge 4.
- Abort plus rose at the same edge (d=3) → neither `pass` nor `fail`, `busy`=0 after that edge. A start at the next edge is accepted.
- Three starts during an attempt plus one at the verdict edge → single verdict. `drop_cnt`=4 with the macro defined, 0 without it. A start with `en`=0 is not counted.
- `rst_n` pulsed low asynchronously at d=3 → all outputs 0 immediately, no verdict after release, `prev_q`=0.
